data_gen_two64: RTL

Test-pattern source for the user-side datapath. It produces 128-bit words made of two independent 64-bit lanes, each lane incrementing by `DATA_INTERVAL` on every accepted beat. Traffic is organised in bursts separated by programmable idle gaps, and a ready/valid handshake lets the downstream sink apply back-pressure. The block sits directly upstream of the two-lane data checker, so the checker's expected sequence (first word 0, then +`DATA_INTERVAL` per valid beat in each lane) is met by construction.

---
 rtl/data_gen_two64.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/data_gen_two64.sv
// Two-lane 128-bit test-pattern source with burst/gap framing, ready/valid
// back-pressure and single-beat error injection. Both 64-bit lanes advance by
// DATA_INTERVAL on every accepted beat, starting from 0 after reset.
module data_gen_two64 #(
    parameter logic [31:0] DATA_INTERVAL = 32'h2
) (
    input  logic          clk_usr,
    input  logic          rst,
    input  logic          enable,
    input  logic [15:0]   burst_len,
    input  logic [15:0]   gap_len,
    input  logic          inject_err,
    input  logic          usr_tx_ready,
    output logic [127:0]  usr_tx,
    output logic          usr_tx_valid,
    output logic          busy,
    output logic [31:0]   word_cnt
);

    typedef enum logic [1:0] {StIdle, StBurst, StGap} state_e;

    localparam logic [63:0] Step = {32'd0, DATA_INTERVAL};

    state_e      state_q, state_d;
    logic [63:0] lane0_q, lane0_d;
    logic [63:0] lane1_q, lane1_d;
    logic        inj_q, inj_d;
    logic [15:0] blen_q, blen_d;
    logic [15:0] glen_q, glen_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] gcnt_q, gcnt_d;
    logic [31:0] cnt_d;
    logic        accept;

    assign accept = usr_tx_valid && usr_tx_ready;

    // Burst/gap sequencing; lengths are only sampled on entry to a burst.
    always_comb begin
        state_d = state_q;
        blen_d  = blen_q;
        glen_d  = glen_q;
        rem_d   = rem_q;
        gcnt_d  = gcnt_q;
        case (state_q)
            StIdle: begin
                if (enable) begin
                    blen_d  = burst_len;
                    glen_d  = gap_len;
                    rem_d   = burst_len;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (accept) begin
                    if (blen_q == 16'd0) begin
                        // Continuous stream: only a dropped enable ends it.
                        if (!enable) state_d = StIdle;
                    end else if (rem_q == 16'd1) begin
                        if (glen_q != 16'd0) begin
                            gcnt_d  = glen_q;
                            state_d = StGap;
                        end else if (enable) begin
                            // Back-to-back burst, valid stays high.
                            blen_d = burst_len;
                            glen_d = gap_len;
                            rem_d  = burst_len;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        rem_d = rem_q - 16'd1;
                    end
                end
            end
            StGap: begin
                if (gcnt_q == 16'd1) begin
                    if (enable) begin
                        blen_d  = burst_len;
                        glen_d  = gap_len;
                        rem_d   = burst_len;
                        state_d = StBurst;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    gcnt_d = gcnt_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Lane/word counters advance on acceptance; pending-error flag bookkeeping.
    always_comb begin
        lane0_d = lane0_q;
        lane1_d = lane1_q;
        cnt_d   = word_cnt;
        inj_d   = inj_q || inject_err;
        if (accept) begin
            lane0_d = lane0_q + Step;
            lane1_d = lane1_q + Step;
            cnt_d   = word_cnt + 32'd1;
            // The beat leaving now consumed any pending flag; a pulse in the
            // same cycle arms the next beat only if nothing was pending.
            inj_d   = inject_err && !inj_q;
        end
    end

    // State and registered outputs; usr_tx reflects the post-edge lanes/flag.
    always_ff @(posedge clk_usr or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            lane0_q      <= 64'd0;
            lane1_q      <= 64'd0;
            inj_q        <= 1'b0;
            blen_q       <= 16'd0;
            glen_q       <= 16'd0;
            rem_q        <= 16'd0;
            gcnt_q       <= 16'd0;
            word_cnt     <= 32'd0;
            usr_tx       <= 128'd0;
            usr_tx_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane0_q      <= lane0_d;
            lane1_q      <= lane1_d;
            inj_q        <= inj_d;
            blen_q       <= blen_d;
            glen_q       <= glen_d;
            rem_q        <= rem_d;
            gcnt_q       <= gcnt_d;
            word_cnt     <= cnt_d;
            usr_tx       <= {lane1_d, lane0_d[63:1], lane0_d[0] ^ inj_d};
            usr_tx_valid <= (state_d == StBurst);
            busy         <= (state_d != StIdle);
        end
    end

endmodule
